// File: rtl/mem_bus.sv
// Memory-side responder: MAR + read buffer with a req/ack bridge to external memory.
// Optional macro MEM_BUS_TIMEOUT_EN adds a per-transaction ack timeout with a sticky err flag.
//
// state | meaning
// IDLE  | no external transaction; strobes may be accepted
// RD    | prefetch read of MAR outstanding (ext_req=1, ext_we=0)
// WR    | posted write of ext_wdata to MAR outstanding (ext_req=1, ext_we=1)
module mem_bus #(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       bus_in,
    input  logic              mem_addr_en,
    input  logic              mem_in_en,
    input  logic              mem_out_en,
    output logic [15:0]       bus_out,
    output logic              mem_ready,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [15:0]       ext_wdata,
    input  logic [15:0]       ext_rdata,
    input  logic              ext_ack,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] mar;
    logic [15:0]       rbuf;
    logic              rvalid;
    logic              idle;
    logic              any_strobe;
    logic              multi_strobe;
    logic              acc_addr;
    logic              acc_in;
    logic              acc_out;
    logic              tmo;

    // Priority addr > in > out; a lower-priority strobe in the same cycle is never
    // accepted, so any multi-strobe cycle reports mem_ready=0.
    always_comb begin
        idle         = (state == IDLE);
        any_strobe   = mem_addr_en | mem_in_en | mem_out_en;
        multi_strobe = (mem_addr_en & mem_in_en) | (mem_addr_en & mem_out_en) |
                       (mem_in_en & mem_out_en);
        acc_addr     = idle & mem_addr_en;
        acc_in       = idle & mem_in_en & ~mem_addr_en;
        acc_out      = idle & mem_out_en & ~mem_addr_en & ~mem_in_en & rvalid;
        mem_ready    = ~any_strobe | (~multi_strobe & (acc_addr | acc_in | acc_out));
        bus_out      = acc_out ? rbuf : 16'h0000;
    end

    assign ext_req  = (state != IDLE);
    assign ext_we   = (state == WR);
    assign ext_addr = mar;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int TMR_W = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMR_W-1:0] tmr;
    logic             err_q;

    // Down-counter reloads every IDLE cycle, so it is fresh on RD/WR entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr   <= '0;
            err_q <= 1'b0;
        end else begin
            if (idle)
                tmr <= TMR_W'(TIMEOUT_CYC - 1);
            else if (tmr != '0)
                tmr <= tmr - 1'b1;
            if (tmo)
                err_q <= 1'b1;
        end
    end

    assign tmo = ~idle & ~ext_ack & (tmr == '0);
    assign err = err_q;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc_addr)
                    state_nxt = RD;
                else if (acc_in)
                    state_nxt = WR;
            end
            RD, WR: begin
                if (ext_ack || tmo)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mar       <= '0;
            rbuf      <= 16'h0000;
            rvalid    <= 1'b0;
            ext_wdata <= 16'h0000;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (acc_addr) begin
                        mar    <= bus_in[ADDR_W-1:0];
                        rvalid <= 1'b0;
                    end else if (acc_in) begin
                        ext_wdata <= bus_in;
                        rbuf      <= bus_in;
                        rvalid    <= 1'b1;
                    end
                end
                RD: begin
                    if (ext_ack) begin
                        rbuf   <= ext_rdata;
                        rvalid <= 1'b1;
                    end else if (tmo) begin
                        // Aborted fetch returns zero, which the sequencer decodes as NOP.
                        rbuf   <= 16'h0000;
                        rvalid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
